// File: rtl/ir_pkg.sv
// Shared types and defaults for the IR packet transmitter: FSM states, field
// indices, bus addresses and default burst/gap lengths.
package ir_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_CARSEL = 3'd2,
        ST_BIT_R  = 3'd3,
        ST_BIT_L  = 3'd4,
        ST_BIT_B  = 3'd5,
        ST_BIT_F  = 3'd6,
        ST_GAP    = 3'd7
    } ir_state_e;

    localparam logic [2:0] FLD_START  = 3'd0;
    localparam logic [2:0] FLD_CARSEL = 3'd1;
    localparam logic [2:0] FLD_R      = 3'd2;
    localparam logic [2:0] FLD_L      = 3'd3;
    localparam logic [2:0] FLD_B      = 3'd4;
    localparam logic [2:0] FLD_F      = 3'd5;

    localparam logic [7:0] DEF_BASE_ADDR = 8'h90;
    localparam logic [7:0] STATUS_OFS    = 8'h01;

    localparam int DEF_START_LEN    = 191;
    localparam int DEF_CARSEL_LEN   = 47;
    localparam int DEF_GAP_LEN      = 25;
    localparam int DEF_ASSERT_LEN   = 47;
    localparam int DEF_DEASSERT_LEN = 22;

    // Burst state that follows a gap, chosen by the field index.
    function automatic ir_state_e fld_to_state(input logic [2:0] fld);
        ir_state_e s;
        case (fld)
            FLD_START:  s = ST_START;
            FLD_CARSEL: s = ST_CARSEL;
            FLD_R:      s = ST_BIT_R;
            FLD_L:      s = ST_BIT_L;
            FLD_B:      s = ST_BIT_B;
            FLD_F:      s = ST_BIT_F;
            default:    s = ST_IDLE;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/ir_packet_tx_if.sv
// CPU bus seen by the IR transmitter: address, write strobe and the shared
// bidirectional data bus.
interface ir_packet_tx_if;
    logic [7:0] bus_addr;
    logic       bus_we;
    wire  [7:0] bus_data;

    modport master (output bus_addr, output bus_we, inout bus_data);
    modport slave  (input bus_addr, input bus_we, inout bus_data);
endinterface

// File: rtl/ir_carrier_gen.sv
// IR carrier generator: phase toggles every HALF_PERIOD clocks while enabled;
// a carrier cycle ends on the falling edge of the phase.
module ir_carrier_gen #(
    parameter int HALF_PERIOD = 625
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_en,
    input  logic i_restart,
    output logic o_phase,
    output logic o_cycle_end
);
    localparam int CW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF_PERIOD - 1);

    logic [CW-1:0] r_cnt;
    logic          r_phase;
    logic          w_half_end;

    assign w_half_end = (r_cnt == HALF_LAST);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt   <= '0;
            r_phase <= 1'b0;
        end else if (!i_en || i_restart) begin
            r_cnt   <= '0;
            r_phase <= 1'b0;
        end else if (w_half_end) begin
            r_cnt   <= '0;
            r_phase <= ~r_phase;
        end else begin
            r_cnt   <= r_cnt + 1'b1;
        end
    end

    assign o_phase     = r_phase;
    assign o_cycle_end = i_en & ~i_restart & r_phase & w_half_end;

endmodule

// File: rtl/ir_packet_tx.sv
// Bus-mapped IR packet transmitter: start, car-select and four command-bit bursts
// per packet tick. Optional status readback is enabled by IR_STATUS_READ_EN.
//
//  state     | meaning
//  ST_IDLE   | waiting for packet tick, carrier stopped
//  ST_START  | start burst
//  ST_CARSEL | car-select burst
//  ST_BIT_x  | command bit burst (R=bit3, L=bit2, B=bit1, F=bit0)
//  ST_GAP    | LED off after a burst; r_fld picks the next burst or IDLE
module ir_packet_tx
    import ir_pkg::*;
#(
    parameter int         CLK_HZ       = 50_000_000,
    parameter int         CARRIER_HZ   = 40_000,
    parameter int         PACKET_HZ    = 10,
    parameter logic [7:0] BASE_ADDR    = DEF_BASE_ADDR,
    parameter int         START_LEN    = DEF_START_LEN,
    parameter int         CARSEL_LEN   = DEF_CARSEL_LEN,
    parameter int         GAP_LEN      = DEF_GAP_LEN,
    parameter int         ASSERT_LEN   = DEF_ASSERT_LEN,
    parameter int         DEASSERT_LEN = DEF_DEASSERT_LEN
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    ir_packet_tx_if.slave  bus,
    output logic           o_ir_led,
    output logic           o_busy
);
    localparam int HALF_PERIOD = CLK_HZ / (2 * CARRIER_HZ);
    localparam int TICK_MAX    = CLK_HZ / PACKET_HZ - 1;
    localparam int TICK_W      = $clog2(TICK_MAX + 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_MAX);
    localparam logic [7:0] STATUS_ADDR = BASE_ADDR + STATUS_OFS;

    ir_state_e         r_state, w_state_nxt;
    logic [2:0]        r_fld, w_fld_nxt;
    logic [7:0]        r_cnt;
    logic [7:0]        w_len;
    logic [3:0]        r_cmd_pending, r_cmd_active;
    logic [TICK_W-1:0] r_tick_cnt;
    logic              r_ir_led, r_busy;
    logic              w_tick, w_wr, w_restart, w_done, w_burst;
    logic              w_phase, w_cyc_end;
    logic [3:0]        w_wr_cmd;
    logic              w_unused_hi;

    assign w_wr        = bus.bus_we && (bus.bus_addr == BASE_ADDR);
    assign w_wr_cmd    = bus.bus_data[3:0];
    assign w_unused_hi = ^bus.bus_data[7:4];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)    r_tick_cnt <= '0;
        else if (w_tick) r_tick_cnt <= '0;
        else             r_tick_cnt <= r_tick_cnt + 1'b1;
    end
    assign w_tick = (r_tick_cnt == TICK_LAST);

    ir_carrier_gen #(.HALF_PERIOD(HALF_PERIOD)) u_carrier (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_en        (r_state != ST_IDLE),
        .i_restart   (w_restart),
        .o_phase     (w_phase),
        .o_cycle_end (w_cyc_end)
    );

    always_comb begin
        w_len = 8'(GAP_LEN);
        case (r_state)
            ST_START:  w_len = 8'(START_LEN);
            ST_CARSEL: w_len = 8'(CARSEL_LEN);
            ST_BIT_R:  w_len = r_cmd_active[3] ? 8'(ASSERT_LEN) : 8'(DEASSERT_LEN);
            ST_BIT_L:  w_len = r_cmd_active[2] ? 8'(ASSERT_LEN) : 8'(DEASSERT_LEN);
            ST_BIT_B:  w_len = r_cmd_active[1] ? 8'(ASSERT_LEN) : 8'(DEASSERT_LEN);
            ST_BIT_F:  w_len = r_cmd_active[0] ? 8'(ASSERT_LEN) : 8'(DEASSERT_LEN);
            default:   w_len = 8'(GAP_LEN);
        endcase
    end

    assign w_done  = w_cyc_end && (r_cnt == w_len - 8'd1);
    assign w_burst = (r_state != ST_IDLE) && (r_state != ST_GAP);

    always_comb begin
        w_state_nxt = r_state;
        w_fld_nxt   = r_fld;
        w_restart   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_tick) begin
                    w_state_nxt = ST_START;
                    w_fld_nxt   = FLD_START;
                    w_restart   = 1'b1;
                end
            end
            ST_GAP: begin
                if (w_done) begin
                    if (r_fld == FLD_F) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_fld_nxt   = r_fld + 3'd1;
                        w_state_nxt = fld_to_state(r_fld + 3'd1);
                    end
                end
            end
            default: begin
                if (w_done) w_state_nxt = ST_GAP;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_fld   <= FLD_START;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_fld   <= w_fld_nxt;
            r_busy  <= (w_state_nxt != ST_IDLE);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)                r_cnt <= '0;
        else if (r_state == ST_IDLE) r_cnt <= '0;
        else if (w_cyc_end)          r_cnt <= w_done ? 8'd0 : r_cnt + 8'd1;
    end

    // A write landing on the tick edge is what the new packet carries.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cmd_pending <= 4'h0;
            r_cmd_active  <= 4'h0;
        end else begin
            if (w_wr) r_cmd_pending <= w_wr_cmd;
            if (r_state == ST_IDLE && w_tick)
                r_cmd_active <= w_wr ? w_wr_cmd : r_cmd_pending;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_ir_led <= 1'b0;
        else          r_ir_led <= w_phase & w_burst;
    end

    assign o_ir_led = r_ir_led;
    assign o_busy   = r_busy;

`ifdef IR_STATUS_READ_EN
    logic       r_rd_en;
    logic [7:0] r_rd_data;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rd_en   <= 1'b0;
            r_rd_data <= 8'h00;
        end else begin
            r_rd_en   <= !bus.bus_we && (bus.bus_addr == STATUS_ADDR);
            r_rd_data <= {r_busy, 3'b000, r_cmd_pending};
        end
    end

    assign bus.bus_data = r_rd_en ? r_rd_data : 8'hzz;
`else
    // Write-only block: the data bus is left undriven.
`endif

endmodule

// File: tb/tb_ir_packet_tx.sv
// Self-checking bench for ir_packet_tx. Carrier and packet rates are sped up
// (half-period 2 clocks, packet period 3200 clocks); burst lengths are the defaults.
module tb_ir_packet_tx;
    localparam int CLK_HZ     = 800_000;
    localparam int CARRIER_HZ = 200_000;
    localparam int PACKET_HZ  = 250;
    localparam int H          = CLK_HZ / (2 * CARRIER_HZ);
    localparam int P          = CLK_HZ / PACKET_HZ;
    localparam int GAP_RUN    = (2 * 25 + 1) * H;
    localparam int TAIL_NOM   = 2 * 25 * H;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       o_ir_led, o_busy;
    logic       drv_en = 1'b0;
    logic [7:0] drv_data = 8'h00;
    int         total = 0;
    int         bad = 0;
    int         cyc;
    logic [3:0] m_pending;

    ir_packet_tx_if ifc ();
    assign ifc.bus_data = drv_en ? drv_data : 8'hzz;

    ir_packet_tx #(
        .CLK_HZ(CLK_HZ), .CARRIER_HZ(CARRIER_HZ), .PACKET_HZ(PACKET_HZ)
    ) dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .bus      (ifc.slave),
        .o_ir_led (o_ir_led),
        .o_busy   (o_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    // Reference packet: burst lengths in carrier cycles, start burst first.
    function automatic logic [47:0] exp_sig(input logic [3:0] c);
        logic [47:0] s;
        s[47:40] = 8'd191;
        s[39:32] = 8'd47;
        for (int i = 0; i < 4; i++)
            s[31-8*i -: 8] = c[3-i] ? 8'd47 : 8'd22;
        return s;
    endfunction

    task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        ifc.bus_addr = a;
        ifc.bus_we   = 1'b1;
        drv_data     = d;
        drv_en       = 1'b1;
        @(negedge clk);
        ifc.bus_we   = 1'b0;
        ifc.bus_addr = 8'h00;
        drv_en       = 1'b0;
    endtask

    // Measures one packet: pulse count per burst, bad pulse/gap widths,
    // LED-low tail before BUSY falls, and start position within the tick period.
    task automatic capture_pkt(output logic [47:0] sig, output int nb, output int bad_t,
                               output int tail, output int smod, output bit tmo);
        int  n, run, pulses;
        bit  prev;
        sig = '0; nb = 0; bad_t = 0; tail = 0; smod = -1; tmo = 1'b0;
        n = 0;
        while (o_busy !== 1'b1 && n < P + 50) begin
            @(negedge clk);
            n++;
        end
        if (o_busy !== 1'b1) begin
            tmo = 1'b1;
            return;
        end
        smod = cyc % P;
        prev = 1'b0; run = 0; pulses = 0; n = 0;
        while (o_busy === 1'b1 && n < P) begin
            if (o_ir_led !== prev) begin
                if (prev) begin
                    if (run != H) bad_t++;
                end else if (pulses > 0) begin
                    if (run == GAP_RUN) begin
                        if (nb < 6) sig[8*(5-nb) +: 8] = 8'(pulses);
                        nb++;
                        pulses = 0;
                    end else if (run != H) begin
                        bad_t++;
                    end
                end
                if (!prev) pulses++;
                prev = (o_ir_led === 1'b1);
                run  = 1;
            end else begin
                run++;
            end
            @(negedge clk);
            n++;
        end
        if (o_busy === 1'b1) tmo = 1'b1;
        if (pulses > 0) begin
            if (nb < 6) sig[8*(5-nb) +: 8] = 8'(pulses);
            nb++;
        end
        tail = prev ? -1 : run;
    endtask

    task automatic test_reset;
        ifc.bus_addr = 8'h00;
        ifc.bus_we   = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (o_ir_led !== 1'b0) begin bad++; $display("FAIL reset_led got=%b exp=0", o_ir_led); end
        total++;
        if (o_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", o_busy); end
        rst_n = 1'b1;
        m_pending = 4'h0;
    endtask

    task automatic test_idle_packets;
        logic [47:0] sig; int nb, bt, tail, smod; bit tmo;
        for (int p = 0; p < 2; p++) begin
            capture_pkt(sig, nb, bt, tail, smod, tmo);
            total++;
            if (tmo || nb != 6 || sig !== exp_sig(m_pending)) begin
                bad++; $display("FAIL idle_pkt%0d bursts got=%h nb=%0d tmo=%0d exp=%h", p, sig, nb, tmo, exp_sig(m_pending));
            end
            total++;
            if (bt != 0 || tail < TAIL_NOM - 2 || tail > TAIL_NOM + 1) begin
                bad++; $display("FAIL idle_pkt%0d timing bad_widths=%0d tail=%0d exp_tail~%0d", p, bt, tail, TAIL_NOM);
            end
            total++;
            if (smod != 0) begin bad++; $display("FAIL idle_pkt%0d start got=%0d exp=0", p, smod); end
        end
    endtask

    task automatic test_cmd_09;
        logic [47:0] sig; int nb, bt, tail, smod; bit tmo;
        bus_write(8'h90, 8'h09);
        m_pending = 4'h9;
        capture_pkt(sig, nb, bt, tail, smod, tmo);
        total++;
        if (tmo || nb != 6 || sig !== exp_sig(m_pending)) begin
            bad++; $display("FAIL cmd09 bursts got=%h nb=%0d exp=%h", sig, nb, exp_sig(m_pending));
        end
        total++;
        if (bt != 0 || tail < TAIL_NOM - 2 || tail > TAIL_NOM + 1) begin
            bad++; $display("FAIL cmd09 timing bad_widths=%0d tail=%0d exp_tail~%0d", bt, tail, TAIL_NOM);
        end
        total++;
        if (smod != 0) begin bad++; $display("FAIL cmd09 start got=%0d exp=0", smod); end
    endtask

    task automatic test_mid_packet_write;
        logic [47:0] sig; int nb, bt, tail, smod, k; bit tmo;
        logic [3:0] old_cmd;
        old_cmd = m_pending;
        fork
            capture_pkt(sig, nb, bt, tail, smod, tmo);
            begin
                k = 0;
                while (o_busy !== 1'b1 && k < P + 50) begin @(negedge clk); k++; end
                repeat ($urandom_range(200, 1800)) @(negedge clk);
                bus_write(8'h90, {4'($urandom), 4'hF});
            end
        join
        m_pending = 4'hF;
        total++;
        if (tmo || nb != 6 || sig !== exp_sig(old_cmd)) begin
            bad++; $display("FAIL midwr_inflight got=%h nb=%0d exp=%h", sig, nb, exp_sig(old_cmd));
        end
        capture_pkt(sig, nb, bt, tail, smod, tmo);
        total++;
        if (tmo || nb != 6 || sig !== exp_sig(m_pending)) begin
            bad++; $display("FAIL midwr_next got=%h nb=%0d exp=%h", sig, nb, exp_sig(m_pending));
        end
        total++;
        if (bt != 0 || smod != 0) begin
            bad++; $display("FAIL midwr_timing bad_widths=%0d start=%0d exp=0,0", bt, smod);
        end
    endtask

    task automatic test_other_addr;
        logic [47:0] sig; int nb, bt, tail, smod; bit tmo;
        logic [3:0] v;
        v = 4'($urandom);
        bus_write(8'h90, {4'($urandom), v});
        m_pending = v;
        bus_write(8'h91, {4'($urandom), ~v});
        bus_write(8'h00, {4'($urandom), ~v});
        capture_pkt(sig, nb, bt, tail, smod, tmo);
        total++;
        if (tmo || nb != 6 || sig !== exp_sig(m_pending)) begin
            bad++; $display("FAIL other_addr got=%h nb=%0d exp=%h", sig, nb, exp_sig(m_pending));
        end
    endtask

    task automatic test_random_cmds;
        logic [47:0] sig; int nb, bt, tail, smod; bit tmo;
        logic [3:0] c;
        for (int i = 0; i < 3; i++) begin
            c = 4'($urandom);
            bus_write(8'h90, {4'($urandom), c});
            m_pending = c;
            capture_pkt(sig, nb, bt, tail, smod, tmo);
            total++;
            if (tmo || nb != 6 || sig !== exp_sig(m_pending)) begin
                bad++; $display("FAIL rand%0d cmd=%h got=%h nb=%0d exp=%h", i, c, sig, nb, exp_sig(m_pending));
            end
            total++;
            if (bt != 0 || tail < TAIL_NOM - 2 || tail > TAIL_NOM + 1 || smod != 0) begin
                bad++; $display("FAIL rand%0d timing bad_widths=%0d tail=%0d start=%0d", i, bt, tail, smod);
            end
        end
    endtask

    task automatic test_write_on_tick;
        logic [47:0] sig; int nb, bt, tail, smod, k; bit tmo;
        logic [3:0] a, b;
        a = 4'($urandom);
        b = ~a;
        bus_write(8'h90, {4'h0, a});
        k = 0;
        while ((cyc % P) != P - 2 && k < P + 10) begin @(negedge clk); k++; end
        bus_write(8'h90, {4'($urandom), b});
        m_pending = b;
        capture_pkt(sig, nb, bt, tail, smod, tmo);
        total++;
        if (tmo || nb != 6 || sig !== exp_sig(b)) begin
            bad++; $display("FAIL wr_on_tick got=%h nb=%0d exp=%h (stale would be %h)", sig, nb, exp_sig(b), exp_sig(a));
        end
        total++;
        if (smod != 0) begin bad++; $display("FAIL wr_on_tick start got=%0d exp=0", smod); end
    endtask

    task automatic test_reset_mid;
        logic [47:0] sig; int nb, bt, tail, smod, k, lr; bit tmo;
        logic [3:0] c;
        c = 4'($urandom);
        bus_write(8'h90, {4'($urandom), c});
        m_pending = c;
        k = 0;
        while (o_busy !== 1'b1 && k < P + 50) begin @(negedge clk); k++; end
        total++;
        if (o_busy !== 1'b1) begin bad++; $display("FAIL rstmid_start busy=%b exp=1", o_busy); end
        lr = c[3] ? 47 : 22;
        repeat (2 * H * (191 + 25 + 47 + 25 + lr + 25) + 2 * H) @(negedge clk);
        k = 0;
        while (o_ir_led !== 1'b1 && k < 4 * H) begin @(negedge clk); k++; end
        total++;
        if (o_ir_led !== 1'b1) begin bad++; $display("FAIL rstmid_bitl_led got=%b exp=1", o_ir_led); end
        rst_n = 1'b0;
        #1;
        total++;
        if (o_ir_led !== 1'b0 || o_busy !== 1'b0) begin
            bad++; $display("FAIL rstmid_drop led=%b busy=%b exp=0,0", o_ir_led, o_busy);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        m_pending = 4'h0;
        k = 0;
        repeat (P - 20) begin
            @(negedge clk);
            if (o_busy !== 1'b0) k++;
        end
        total++;
        if (k != 0) begin bad++; $display("FAIL rstmid_idle busy_samples=%0d exp=0", k); end
        capture_pkt(sig, nb, bt, tail, smod, tmo);
        total++;
        if (tmo || nb != 6 || sig !== exp_sig(4'h0) || smod != 0) begin
            bad++; $display("FAIL rstmid_next got=%h nb=%0d start=%0d exp=%h,0", sig, nb, smod, exp_sig(4'h0));
        end
    endtask

`ifdef IR_STATUS_READ_EN
    task automatic test_status_read;
        int k;
        bus_write(8'h90, {4'($urandom), 4'h5});
        k = 0;
        while (o_busy !== 1'b1 && k < P + 50) begin @(negedge clk); k++; end
        ifc.bus_addr = 8'h91;
        ifc.bus_we   = 1'b0;
        @(negedge clk);
        total++;
        if (ifc.bus_data !== 8'h85) begin bad++; $display("FAIL status_read got=%h exp=85", ifc.bus_data); end
        ifc.bus_addr = 8'h92;
        @(negedge clk);
        drv_data = 8'h3C;
        drv_en   = 1'b1;
        #1;
        total++;
        if (ifc.bus_data !== 8'h3C) begin bad++; $display("FAIL status_release got=%h exp=3c", ifc.bus_data); end
        drv_en = 1'b0;
        ifc.bus_addr = 8'h00;
    endtask
`endif

    initial begin
        test_reset();
        test_idle_packets();
        test_cmd_09();
        test_mid_packet_write();
        test_other_addr();
        test_random_cmds();
        test_write_on_tick();
        test_reset_mid();
`ifdef IR_STATUS_READ_EN
        test_status_read();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
